typed_fifo: RTL

TYPED_FIFO -- requirements
Module: typed_fifo

---
 rtl/typed_fifo_pkg.sv | 11 +
 rtl/typed_fifo_ctrl.sv | 72 +++++++
 rtl/typed_fifo.sv | 68 ++++++
 3 files changed

// File: rtl/typed_fifo_pkg.sv
// Shared constants and helpers for the typed FIFO.
package typed_fifo_pkg;

  localparam int unsigned TYPED_FIFO_MAX_DEPTH = 256;

  // Advance a pointer by one, wrapping at depth-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/typed_fifo_ctrl.sv
// Pointer / full / empty bookkeeping for typed_fifo; independent of the payload type.
// With TYPED_FIFO_COUNT_EN defined an occupancy register drives full/empty and count;
// otherwise full/empty come from pointer equality plus a single wrap flag.
module typed_fifo_ctrl
  import typed_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push,
  input  logic            pop,
  output logic [PtrW-1:0] wrPtr,
  output logic [PtrW-1:0] rdPtr,
  output logic            full,
  output logic            empty
`ifdef TYPED_FIFO_COUNT_EN
  ,
  output logic [CntW-1:0] count
`endif
);

  // Pointer update; reset and flush override any push or pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= PtrW'(ptr_next(32'(wrPtr), DEPTH));
      if (pop)  rdPtr <= PtrW'(ptr_next(32'(rdPtr), DEPTH));
    end
  end

`ifdef TYPED_FIFO_COUNT_EN
  // Occupancy register; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CntW'(1);
    end else if (pop && !push) begin
      count <= count - CntW'(1);
    end
  end

  assign full  = (count == CntW'(DEPTH));
  assign empty = (count == '0);
`else
  logic wrapFlag;
  logic wrWrap;
  logic rdWrap;

  assign wrWrap = push && (wrPtr == PtrW'(DEPTH - 1));
  assign rdWrap = pop  && (rdPtr == PtrW'(DEPTH - 1));

  // Wrap flag is set while the write pointer is one lap ahead of the read pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrapFlag <= 1'b0;
    end else begin
      wrapFlag <= wrapFlag ^ wrWrap ^ rdWrap;
    end
  end

  assign full  = (wrPtr == rdPtr) &&  wrapFlag;
  assign empty = (wrPtr == rdPtr) && !wrapFlag;
`endif

endmodule

// File: rtl/typed_fifo.sv
// Typed valid/ready FIFO with no fall-through and no push-when-full bypass.
// Optional macro TYPED_FIFO_COUNT_EN adds the count_o occupancy port.
module typed_fifo
  import typed_fifo_pkg::*;
#(
  parameter type data_t = logic [8:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  data_t in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output data_t out_data_o
`ifdef TYPED_FIFO_COUNT_EN
  ,
  output logic [CntW-1:0] count_o
`endif
);

  if (DEPTH < 2 || DEPTH > TYPED_FIFO_MAX_DEPTH) begin : gDepthCheck
    $error("typed_fifo: DEPTH must be within 2..TYPED_FIFO_MAX_DEPTH");
  end

  data_t           mem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign in_ready_o  = !full && !rst_i;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  typed_fifo_ctrl #(.DEPTH(DEPTH)) uCtrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push    (push),
    .pop     (pop),
    .wrPtr   (wrPtr),
    .rdPtr   (rdPtr),
    .full    (full),
    .empty   (empty)
`ifdef TYPED_FIFO_COUNT_EN
    ,
    .count   (count_o)
`endif
  );

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wrPtr] <= in_data_i;
    end
  end

  assign out_data_o = mem[rdPtr];

endmodule
